// File: rtl/l2_mshr_alloc_pkg.sv
// Shared constants and types for the L2 MSHR allocator.
package l2_mshr_alloc_pkg;

   localparam int unsigned N_MSHR       = 4;
   localparam int unsigned MSHR_BITS    = 2;
   localparam int unsigned MSHR_BITS_P1 = MSHR_BITS + 1;
   localparam int unsigned L2_SET_BITS  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } mshr_fsm_e;

endpackage

// File: rtl/l2_mshr_alloc_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot and binary index of the first requester.
module mshr_prio_enc #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Scan from the top down so the lowest index wins.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_onehot = '0;
            o_onehot[i] = 1'b1;
            o_idx    = IDX_W'(i);
            o_any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l2_mshr_alloc.sv
// L2 miss-status holding register allocator: grants the lowest free entry,
// tracks per-entry set for conflict detection, and supports a flush drain.
module l2_mshr_alloc
   import l2_mshr_alloc_pkg::*;
#(
   parameter int unsigned N_MSHR = l2_mshr_alloc_pkg::N_MSHR,
   parameter int unsigned SET_W  = l2_mshr_alloc_pkg::L2_SET_BITS,
   parameter int unsigned IDX_W  = (N_MSHR > 1) ? $clog2(N_MSHR) : 1,
   parameter int unsigned CNT_W  = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req,
   input  logic [SET_W-1:0] alloc_set,
   output logic             alloc_gnt,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             free_valid,
   input  logic [IDX_W-1:0] free_idx,
   input  logic             flush_req,
   output logic             set_conflict,
   output logic [CNT_W-1:0] mshr_cnt,
   output logic             mshr_full,
   output logic             mshr_empty,
   output logic             flush_done,
   output logic             free_err
);

   logic [N_MSHR-1:0] r_valid;
   logic [SET_W-1:0]  r_set [N_MSHR];
   logic [CNT_W-1:0]  r_cnt;
   logic              r_free_err;
   mshr_fsm_e         r_state;
   mshr_fsm_e         w_state_nxt;

   logic [N_MSHR-1:0] w_free_onehot;
   logic [IDX_W-1:0]  w_free_slot;
   logic              w_any_free;
   logic              w_conflict;
   logic              w_free_legal;
   logic              w_gnt;

   mshr_prio_enc #(
      .N     (N_MSHR),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .i_req    (~r_valid),
      .o_onehot (w_free_onehot),
      .o_idx    (w_free_slot),
      .o_any    (w_any_free)
   );

   // Entries being freed this cycle still hold their set and block a match.
   always_comb begin
      w_conflict = 1'b0;
      for (int i = 0; i < int'(N_MSHR); i++) begin
         if (r_valid[i] && (r_set[i] == alloc_set)) w_conflict = 1'b1;
      end
   end

   always_comb begin
      w_free_legal = 1'b0;
      if (free_valid && (32'(free_idx) < N_MSHR)) w_free_legal = r_valid[free_idx];
   end

   assign mshr_full  = (r_cnt == CNT_W'(0));
   assign mshr_empty = (r_cnt == CNT_W'(N_MSHR));
   assign w_gnt      = rst && alloc_req && !mshr_full && !w_conflict &&
                       w_any_free && (r_state == ST_IDLE);

   assign alloc_gnt    = w_gnt;
   assign alloc_idx    = w_free_slot;
   assign set_conflict = w_conflict;
   assign mshr_cnt     = r_cnt;
   assign free_err     = r_free_err;
   assign flush_done   = (r_state == ST_DONE);

   // Next-state logic for the flush drain sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (flush_req) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (mshr_empty) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid    <= '0;
         r_cnt      <= CNT_W'(N_MSHR);
         r_free_err <= 1'b0;
         r_state    <= ST_IDLE;
         for (int i = 0; i < int'(N_MSHR); i++) r_set[i] <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_free_err <= free_valid && !w_free_legal;
         if (w_gnt) begin
            for (int i = 0; i < int'(N_MSHR); i++) begin
               if (w_free_onehot[i]) r_set[i] <= alloc_set;
            end
         end
         r_valid <= (r_valid | (w_gnt ? w_free_onehot : '0)) &
                    ~(w_free_legal ? (N_MSHR'(1) << free_idx) : '0);
         case ({w_gnt, w_free_legal})
            2'b10:   r_cnt <= r_cnt - CNT_W'(1);
            2'b01:   r_cnt <= r_cnt + CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Directed self-checking bench for l2_mshr_alloc.
module tb_l2_mshr_alloc;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic [7:0] alloc_set;
   logic       alloc_gnt;
   logic [1:0] alloc_idx;
   logic       free_valid;
   logic [1:0] free_idx;
   logic       flush_req;
   logic       set_conflict;
   logic [2:0] mshr_cnt;
   logic       mshr_full;
   logic       mshr_empty;
   logic       flush_done;
   logic       free_err;

   int errors = 0;
   int checks = 0;

   l2_mshr_alloc dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_set    (alloc_set),
      .alloc_gnt    (alloc_gnt),
      .alloc_idx    (alloc_idx),
      .free_valid   (free_valid),
      .free_idx     (free_idx),
      .flush_req    (flush_req),
      .set_conflict (set_conflict),
      .mshr_cnt     (mshr_cnt),
      .mshr_full    (mshr_full),
      .mshr_empty   (mshr_empty),
      .flush_done   (flush_done),
      .free_err     (free_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic free_one(input logic [1:0] idx);
      free_valid = 1'b1;
      free_idx   = idx;
      tick();
      free_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; alloc_req = 1'b1; alloc_set = 8'h01;
      free_valid = 1'b0; free_idx = 2'd0; flush_req = 1'b0;
      tick(); tick();
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%0b exp=0", alloc_gnt); end
      checks++; if (mshr_cnt !== 3'd4) begin errors++; $display("FAIL reset_cnt got=%0d exp=4", mshr_cnt); end
      checks++; if (mshr_empty !== 1'b1 || mshr_full !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=10", mshr_empty, mshr_full); end
      checks++; if (flush_done !== 1'b0 || free_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%0b%0b exp=00", flush_done, free_err); end
      alloc_req = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         alloc_req = 1'b1; alloc_set = 8'h10 + 8'(i);
         #1;
         checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'(i)) begin errors++; $display("FAIL fill_gnt%0d got=%0b/%0d exp=1/%0d", i, alloc_gnt, alloc_idx, i); end
         checks++; if (mshr_cnt !== 3'(4 - i)) begin errors++; $display("FAIL fill_cnt%0d got=%0d exp=%0d", i, mshr_cnt, 4 - i); end
         tick();
      end
      alloc_set = 8'h20;
      #1;
      checks++; if (mshr_cnt !== 3'd0 || mshr_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0d/%0b exp=0/1", mshr_cnt, mshr_full); end
      checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL fifth_gnt got=%0b exp=0", alloc_gnt); end
      alloc_req = 1'b0;
   endtask

   task automatic test_free_realloc();
      free_valid = 1'b1; free_idx = 2'd2; alloc_set = 8'h12;
      #1;
      checks++; if (set_conflict !== 1'b1) begin errors++; $display("FAIL freeing_conflict got=%0b exp=1", set_conflict); end
      tick();
      free_valid = 1'b0;
      checks++; if (mshr_cnt !== 3'd1) begin errors++; $display("FAIL free_cnt got=%0d exp=1", mshr_cnt); end
      alloc_req = 1'b1; alloc_set = 8'h30;
      #1;
      checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd2) begin errors++; $display("FAIL realloc got=%0b/%0d exp=1/2", alloc_gnt, alloc_idx); end
      tick();
      alloc_req = 1'b0;
      for (int i = 0; i < 4; i++) free_one(2'(i));
      checks++; if (mshr_cnt !== 3'd4 || mshr_empty !== 1'b1) begin errors++; $display("FAIL drain_all got=%0d/%0b exp=4/1", mshr_cnt, mshr_empty); end
   endtask

   task automatic test_conflict();
      alloc_req = 1'b1; alloc_set = 8'h15;
      tick();
      #1;
      checks++; if (set_conflict !== 1'b1 || alloc_gnt !== 1'b0) begin errors++; $display("FAIL conflict_block got=%0b/%0b exp=1/0", set_conflict, alloc_gnt); end
      alloc_req = 1'b0;
      #1;
      checks++; if (set_conflict !== 1'b1) begin errors++; $display("FAIL conflict_noreq got=%0b exp=1", set_conflict); end
      alloc_req = 1'b1; free_valid = 1'b1; free_idx = 2'd0;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL same_cycle_regrant got=%0b exp=0", alloc_gnt); end
      tick();
      free_valid = 1'b0;
      #1;
      checks++; if (set_conflict !== 1'b0 || alloc_gnt !== 1'b1 || alloc_idx !== 2'd0) begin errors++; $display("FAIL after_free got=%0b/%0b/%0d exp=0/1/0", set_conflict, alloc_gnt, alloc_idx); end
      tick();
      alloc_req = 1'b0;
   endtask

   task automatic test_same_cycle();
      alloc_req = 1'b1; alloc_set = 8'h16;
      tick();
      checks++; if (mshr_cnt !== 3'd2) begin errors++; $display("FAIL cnt_two got=%0d exp=2", mshr_cnt); end
      alloc_set = 8'h17; free_valid = 1'b1; free_idx = 2'd0;
      #1;
      checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd2) begin errors++; $display("FAIL gnt_with_free got=%0b/%0d exp=1/2", alloc_gnt, alloc_idx); end
      tick();
      alloc_req = 1'b0; free_valid = 1'b0;
      checks++; if (mshr_cnt !== 3'd2) begin errors++; $display("FAIL cnt_hold got=%0d exp=2", mshr_cnt); end
      free_one(2'd0);
      checks++; if (free_err !== 1'b1 || mshr_cnt !== 3'd2) begin errors++; $display("FAIL bad_free got=%0b/%0d exp=1/2", free_err, mshr_cnt); end
      tick();
      checks++; if (free_err !== 1'b0) begin errors++; $display("FAIL bad_free_pulse got=%0b exp=0", free_err); end
      free_one(2'd1);
      free_one(2'd2);
      checks++; if (mshr_cnt !== 3'd4 || free_err !== 1'b0) begin errors++; $display("FAIL cleanup got=%0d/%0b exp=4/0", mshr_cnt, free_err); end
   endtask

   task automatic observe_flush(input string name);
      int first = -1;
      int hits  = 0;
      for (int k = 0; k < 4; k++) begin
         if (flush_done === 1'b1) begin
            hits++;
            if (first < 0) first = k;
         end
         tick();
      end
      checks++; if (first < 1 || first > 2 || hits != 1) begin errors++; $display("FAIL %s got=first%0d/hits%0d exp=first1..2/hits1", name, first, hits); end
   endtask

   task automatic test_flush();
      alloc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alloc_set = 8'h40 + 8'(i);
         tick();
      end
      alloc_req = 1'b0;
      free_one(2'd0);
      free_one(2'd2);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      alloc_req = 1'b1; alloc_set = 8'h50;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL drain_block got=%0b exp=0", alloc_gnt); end
      alloc_req = 1'b0;
      free_one(2'd1);
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL early_done got=%0b exp=0", flush_done); end
      free_valid = 1'b1; free_idx = 2'd3;
      #1;
      tick();
      free_valid = 1'b0;
      // window starts one cycle after the last free
      observe_flush("flush_after_free");
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      observe_flush("flush_empty");
      alloc_req = 1'b1; alloc_set = 8'h60;
      #1;
      checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd0) begin errors++; $display("FAIL post_flush_gnt got=%0b/%0d exp=1/0", alloc_gnt, alloc_idx); end
      tick();
      alloc_req = 1'b0;
      free_one(2'd0);
   endtask

   task automatic test_reset_drain();
      int hits = 0;
      alloc_req = 1'b1; alloc_set = 8'h70;
      tick();
      alloc_req = 1'b0; flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (mshr_cnt !== 3'd4) begin errors++; $display("FAIL rst_drain_cnt got=%0d exp=4", mshr_cnt); end
      for (int k = 0; k < 4; k++) begin
         if (flush_done === 1'b1) hits++;
         tick();
      end
      checks++; if (hits != 0) begin errors++; $display("FAIL rst_drain_done got=%0d exp=0", hits); end
      alloc_req = 1'b1; alloc_set = 8'h70;
      #1;
      checks++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd0) begin errors++; $display("FAIL rst_drain_idle got=%0b/%0d exp=1/0", alloc_gnt, alloc_idx); end
      tick();
      alloc_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_free_realloc();
      test_conflict();
      test_same_cycle();
      test_flush();
      test_reset_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
